// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types for the round-robin multiplier scheduler.
// Status/state encodings, operand/result types and parity helpers.
package mult_rr_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ARG_PERR = 2'd1,
    ST_RES_PERR = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES,
    S_RESPOND
  } state_t;

  typedef logic signed [15:0] operand_t;
  typedef logic signed [31:0] result_t;

  function automatic logic par_op(operand_t v);
    return ^v;
  endfunction

  function automatic logic par_res(result_t v);
    return ^v;
  endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Requester-side and multiplier-side bundles for the scheduler.
// slave/master modports give the scheduler's view of each bundle.
interface mult_rr_req_if
  import mult_rr_pkg::*;
#(
  parameter int N = 4
) ();
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*16-1:0] in_a;
  logic [N*16-1:0] in_b;
  logic            inject_perr;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  result_t         out_result;
  status_t         out_status;

  modport slave (
    input  in_valid, in_a, in_b,
    input  inject_perr, out_ready,
    output in_ready, out_valid,
    output out_result, out_status
  );

  modport master (
    output in_valid, in_a, in_b,
    output inject_perr, out_ready,
    input  in_ready, out_valid,
    input  out_result, out_status
  );
endinterface

interface mult_rr_mul_if
  import mult_rr_pkg::*;
();
  operand_t mul_arg_a;
  operand_t mul_arg_b;
  logic     mul_arg_a_parity;
  logic     mul_arg_b_parity;
  logic     mul_req;
  logic     mul_ack;
  result_t  mul_result;
  logic     mul_result_parity;
  logic     mul_result_rdy;
  logic     mul_arg_parity_error;

  modport master (
    output mul_arg_a, mul_arg_b,
    output mul_arg_a_parity,
    output mul_arg_b_parity,
    output mul_req,
    input  mul_ack, mul_result,
    input  mul_result_parity,
    input  mul_result_rdy,
    input  mul_arg_parity_error
  );

  modport slave (
    input  mul_arg_a, mul_arg_b,
    input  mul_arg_a_parity,
    input  mul_arg_b_parity,
    input  mul_req,
    output mul_ack, mul_result,
    output mul_result_parity,
    output mul_result_rdy,
    output mul_arg_parity_error
  );
endinterface

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid index after the pointer.
// Grant is one-hot; o_any flags that some requester is valid.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int          w_k;
  logic [IW-1:0] w_j;
  logic        w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_j     = '0;
    for (int k = 1; k <= N; k++) begin
      w_k = int'(i_ptr) + k;
      if (w_k >= N) w_k = w_k - N;
      w_j = IW'(w_k);
      if (!w_found && i_valid[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one parity-protected 16x16 multiplier.
// FSM: IDLE -> ISSUE -> WAIT_RES -> RESPOND, with timeout and status.
module mult_rr_scheduler
  import mult_rr_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic         clock,
  input logic         reset,
  mult_rr_req_if.slave req,
  mult_rr_mul_if.master mul
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  state_t        r_state, w_state;
  logic [IW-1:0] r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic          w_any;
  operand_t      r_a, r_b;
  logic          r_pa, r_pb, r_inj;
  logic [TW-1:0] r_tmo;
  result_t       r_res, w_res;
  status_t       r_sts, w_sts;
  logic          w_accept, w_done, w_to, w_tmo, w_inj;
  operand_t      w_a [NUM_REQ];
  operand_t      w_b [NUM_REQ];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_valid (req.in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a[i] = req.in_a[i*16 +: 16];
      w_b[i] = req.in_b[i*16 +: 16];
    end
  end

  assign w_tmo = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_inj = r_inj | req.inject_perr;

  always_comb begin
    w_sts = ST_OK;
    if (mul.mul_arg_parity_error)
      w_sts = ST_ARG_PERR;
    else if (mul.mul_result_parity != par_res(mul.mul_result))
      w_sts = ST_RES_PERR;
    w_res = (w_sts == ST_OK) ? mul.mul_result : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state  = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_to     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept = 1'b1;
          w_state  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul.mul_ack && mul.mul_result_rdy) begin
          w_done  = 1'b1;
          w_state = S_RESPOND;
        end else if (w_tmo) begin
          w_to    = 1'b1;
          w_state = S_RESPOND;
        end else if (mul.mul_ack) begin
          w_state = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (mul.mul_result_rdy) begin
          w_done  = 1'b1;
          w_state = S_RESPOND;
        end else if (w_tmo) begin
          w_to    = 1'b1;
          w_state = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (req.out_ready[r_id]) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= IW'(NUM_REQ - 1);
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_pa  <= 1'b0;
      r_pb  <= 1'b0;
      r_inj <= 1'b0;
      r_tmo <= '0;
      r_res <= '0;
      r_sts <= ST_OK;
    end else begin
      if (w_accept) begin
        r_a   <= w_a[w_idx];
        r_b   <= w_b[w_idx];
        r_pa  <= par_op(w_a[w_idx]) ^ w_inj;
        r_pb  <= par_op(w_b[w_idx]);
        r_id  <= w_idx;
        r_ptr <= w_idx;
        r_inj <= 1'b0;
        r_tmo <= '0;
      end else begin
        r_inj <= w_inj;
        if (r_state == S_ISSUE || r_state == S_WAIT_RES)
          r_tmo <= r_tmo + TW'(1);
      end
      if (w_done) begin
        r_res <= w_res;
        r_sts <= w_sts;
      end else if (w_to) begin
        r_res <= '0;
        r_sts <= ST_TIMEOUT;
      end
    end
  end

  // in_ready is gated by reset so every output reads 0 while held in reset
  assign req.in_ready   = (r_state == S_IDLE && reset) ? w_grant : '0;
  assign req.out_valid  = (r_state == S_RESPOND) ?
                          (NUM_REQ'(1) << r_id) : '0;
  assign req.out_result = r_res;
  assign req.out_status = r_sts;

  assign mul.mul_req          = (r_state == S_ISSUE);
  assign mul.mul_arg_a        = r_a;
  assign mul.mul_arg_b        = r_b;
  assign mul.mul_arg_a_parity = r_pa;
  assign mul.mul_arg_b_parity = r_pb;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: behavioural core, round-robin model,
// directed and random transactions checked with immediate assertions.
module tb_mult_rr_scheduler;
  import mult_rr_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  localparam int C_OK     = 0;
  localparam int C_NOACK  = 1;
  localparam int C_NORDY  = 2;
  localparam int C_BADPAR = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_rr_req_if #(.N(N)) rq ();
  mult_rr_mul_if mi ();

  mult_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clock (clock),
    .reset (reset),
    .req   (rq.slave),
    .mul   (mi.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int core_mode = C_OK;
  bit core_ph   = 1'b0;
  logic signed [15:0] ca, cb;
  logic cpa, cpb;

  // model state
  int m_ptr = N - 1;
  bit m_inj = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // behavioural multiplier core: ack one cycle into req, result the next
  initial begin
    logic signed [31:0] p;
    mi.mul_ack = 1'b0;
    mi.mul_result = '0;
    mi.mul_result_parity = 1'b0;
    mi.mul_result_rdy = 1'b0;
    mi.mul_arg_parity_error = 1'b0;
    ca = '0; cb = '0; cpa = 1'b0; cpb = 1'b0;
    forever begin
      @(negedge clock);
      mi.mul_ack = 1'b0;
      mi.mul_result_rdy = 1'b0;
      mi.mul_arg_parity_error = 1'b0;
      mi.mul_result = '0;
      mi.mul_result_parity = 1'b0;
      if (!reset) begin
        core_ph = 1'b0;
      end else if (core_ph) begin
        core_ph = 1'b0;
        if (core_mode != C_NORDY) begin
          mi.mul_result_rdy = 1'b1;
          if (core_mode == C_BADPAR) begin
            mi.mul_result = 32'sd1;
            mi.mul_result_parity = 1'b0;
          end else begin
            p = ca * cb;
            mi.mul_result = p;
            mi.mul_result_parity = ^p;
            mi.mul_arg_parity_error = (cpa != ^ca) || (cpb != ^cb);
          end
        end
      end else if (mi.mul_req && core_mode != C_NOACK) begin
        mi.mul_ack = 1'b1;
        core_ph = 1'b1;
        ca = mi.mul_arg_a;
        cb = mi.mul_arg_b;
        cpa = mi.mul_arg_a_parity;
        cpb = mi.mul_arg_b_parity;
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      rq.in_a[i*16 +: 16] = 16'($urandom);
      rq.in_b[i*16 +: 16] = 16'($urandom);
    end
  endtask

  task automatic txn(input logic [N-1:0] mask, input bit keep,
                     output int win);
    int w, cyc, reqcyc, exp_res;
    logic signed [15:0] ea, eb;
    bit einj;
    status_t es;
    logic [N-1:0] oh;
    @(negedge clock);
    rq.in_valid = mask;
    #1;
    w = pick(mask);
    win = w;
    oh = N'(1) << w;
    chk("in_ready", 32'(rq.in_ready), 32'(oh));
    ea = rq.in_a[w*16 +: 16];
    eb = rq.in_b[w*16 +: 16];
    einj = m_inj;
    m_inj = 1'b0;
    m_ptr = w;
    if (einj)                     es = ST_ARG_PERR;
    else if (core_mode == C_BADPAR) es = ST_RES_PERR;
    else if (core_mode == C_NOACK)  es = ST_TIMEOUT;
    else                          es = ST_OK;
    exp_res = (es == ST_OK) ? int'(ea) * int'(eb) : 0;
    @(posedge clock);
    #1;
    if (!keep) rq.in_valid = '0;
    rand_ops();
    cyc = 0;
    reqcyc = 0;
    while (rq.out_valid == '0 && cyc < 200) begin
      @(negedge clock);
      if (mi.mul_req) reqcyc++;
      cyc++;
    end
    chk("resp_in_time", 32'(cyc < 200), 32'd1);
    chk("out_valid", 32'(rq.out_valid), 32'(oh));
    chk("out_result", 32'(rq.out_result), 32'(exp_res));
    chk("out_status", 32'(rq.out_status), 32'(es));
    if (core_mode == C_NOACK)
      chk("req_cycles", 32'(reqcyc), 32'(TO));
    else begin
      chk("par_a", 32'(cpa), 32'(^ea ^ einj));
      chk("par_b", 32'(cpb), 32'(^eb));
    end
    rq.out_ready = ~oh;
    @(negedge clock);
    chk("hold_valid", 32'(rq.out_valid), 32'(oh));
    chk("hold_result", 32'(rq.out_result), 32'(exp_res));
    rq.out_ready = oh;
    @(posedge clock);
    #1;
    chk("released", 32'(rq.out_valid), 32'd0);
    rq.out_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [N-1:0] m;
    rq.in_valid = '0;
    rq.in_a = '0;
    rq.in_b = '0;
    rq.inject_perr = 1'b0;
    rq.out_ready = '0;
    #1;
    chk("rst_in_ready", 32'(rq.in_ready), 32'd0);
    chk("rst_out_valid", 32'(rq.out_valid), 32'd0);
    chk("rst_mul_req", 32'(mi.mul_req), 32'd0);
    chk("rst_result", 32'(rq.out_result), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // 1: req0 3 * -5
    rq.in_a[0 +: 16] = 16'sd3;
    rq.in_b[0 +: 16] = -16'sd5;
    txn(4'b0001, 1'b0, w);
    chk("t1_winner", 32'(w), 32'd0);

    // 2: all valid continuously, 8 ops
    rand_ops();
    for (int i = 0; i < 8; i++) txn(4'b1111, 1'b1, w);
    rq.in_valid = '0;

    // 3: injected operand parity error on req1, 7 * 7
    @(negedge clock);
    rq.inject_perr = 1'b1;
    m_inj = 1'b1;
    @(negedge clock);
    rq.inject_perr = 1'b0;
    rq.in_a[16 +: 16] = 16'sd7;
    rq.in_b[16 +: 16] = 16'sd7;
    txn(4'b0010, 1'b0, w);

    // 4: bad result parity
    core_mode = C_BADPAR;
    txn(4'b0100, 1'b0, w);

    // 5: no ack -> timeout, then a normal op
    core_mode = C_NOACK;
    txn(4'b1000, 1'b0, w);
    core_mode = C_OK;
    txn(4'b1001, 1'b0, w);

    // extreme operands
    rq.in_a[32 +: 16] = 16'h8000;
    rq.in_b[32 +: 16] = 16'h8000;
    txn(4'b0100, 1'b0, w);
    rq.in_a[48 +: 16] = 16'h7fff;
    rq.in_b[48 +: 16] = 16'h8000;
    txn(4'b1000, 1'b0, w);

    // random masks and operands
    for (int i = 0; i < 10; i++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      rand_ops();
      txn(m, 1'b0, w);
    end

    // 6: reset while waiting for the result
    core_mode = C_NORDY;
    @(negedge clock);
    rq.in_valid = 4'b0100;
    @(posedge clock);
    #1;
    rq.in_valid = '0;
    repeat (3) @(negedge clock);
    chk("t6_in_wait", 32'(mi.mul_req), 32'd0);
    #2;
    rq.in_valid = '1;
    reset = 1'b0;
    #1;
    chk("t6_mul_req", 32'(mi.mul_req), 32'd0);
    chk("t6_out_valid", 32'(rq.out_valid), 32'd0);
    chk("t6_in_ready", 32'(rq.in_ready), 32'd0);
    chk("t6_arg_a", 32'(mi.mul_arg_a), 32'd0);
    rq.in_valid = '0;
    m_ptr = N - 1;
    m_inj = 1'b0;
    core_mode = C_OK;
    @(negedge clock);
    reset = 1'b1;
    rand_ops();
    txn(4'b1111, 1'b0, w);
    chk("t6_winner", 32'(w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
